conv3d_sched_mc: RTL
====================

// Module: conv3d_sched_mc
// PURPOSE
//  Multi-channel pass scheduler for the conv3d datapath; successor to the single-pass conv3d scheduler.
//  One configuration runs CIN x COUT conv2d passes: for each output channel, every input channel is
//  convolved in turn and accumulated into one output plane. Per pass it broadcasts base addresses and
//  geometry to rmem/core/wmem, then waits for wmem's flag_write_over before issuing the next pass.
// PARAMETERS
//  AW  30  address width (bytes) of all base/offset/param addresses
//  CW  10  channel-count width; cfg_cin/cfg_cout range 1..2^CW-1
//  KS  3   kernel size; informational, forwarded to nothing, kept for parameter-list uniformity
// PORTS
//  clk               in   1    single clock, rising edge
//  rst               in   1    asynchronous, active-low reset
//  cfg_ena           in   1    1-cycle pulse: latch all cfg_* and start a job
//  cfg_xbase         in   AW   input feature base, channel 0
//  cfg_ybase         in   AW   weight base, (co=0,ci=0)
//  cfg_zbase         in   AW   output base, channel 0
//  cfg_xoffset       in   AW   stride between input-channel planes
//  cfg_yoffset       in   AW   stride between consecutive KSxKS weight sets
//  cfg_zoffset       in   AW   stride between output-channel planes
//  cfg_cin           in   CW   input channel count
//  cfg_cout          in   CW   output channel count
//  cfg_width_in      in   9    input width, forwarded
//  cfg_height_out    in   9    output height, forwarded
//  cfg_length_in     in   18   input plane length, forwarded
//  cfg_length_out    in   18   output plane length, forwarded
//  abort             in   1    1-cycle pulse: abandon job
//  flag_write_over   in   1    1-cycle pulse from wmem: current pass fully written
//  param_ena         out  1    1-cycle pulse: new pass parameters valid
//  param_xaddr/yaddr/zaddr out AW  pass addresses
//  param_width_in/height_out out 9; param_length_in/length_out out 18   forwarded geometry
//  param_accum       out  1    0: first ci of this co (overwrite), 1: accumulate onto existing z
//  param_last        out  1    1: last ci of this co (output plane final)
//  busy              out  1    job in progress
//  done              out  1    1-cycle pulse: job completed normally
//  cfg_err           out  1    1-cycle pulse: cfg_ena rejected (cin==0 or cout==0)
// BEHAVIOUR
//  Reset (rst=0): state IDLE, every output and internal register 0.
//  FSM IDLE -> ISSUE -> WAIT -> NEXT -> ISSUE ... -> DONE -> IDLE.
//  IDLE: cfg_ena with cin,cout!=0 latches cfg, ci=co=0, x=xbase, y=ybase, z=zbase, busy=1 -> ISSUE.
//   cfg_ena with cin==0 or cout==0: cfg_err=1 next cycle, stay IDLE, busy stays 0.
//  ISSUE: param_ena=1 for exactly one cycle; param_* registered; -> WAIT. param_* hold until next ISSUE.
//  WAIT: on flag_write_over -> NEXT (or DONE if ci==cin-1 and co==cout-1).
//  NEXT: if ci<cin-1: ci++, x+=xoffset. else ci=0, co++, x=xbase, z+=zoffset. y+=yoffset always. -> ISSUE.
//  DONE: done=1 and busy=0 in the same cycle -> IDLE.
//  Latency: cfg_ena in cycle 0 -> param_ena in cycle 2; flag_write_over in cycle t -> param_ena t+2.
//   final flag_write_over in cycle t -> done in cycle t+1.
//  param_accum = (ci!=0); param_last = (ci==cin-1); both valid with param_ena.
//  Address arithmetic modulo 2^AW, wrap silent. Total passes = cin*cout.
//  cfg_ena while busy: ignored, no cfg_err. flag_write_over in IDLE/ISSUE/NEXT/DONE: ignored.
//  abort (any non-IDLE state): -> IDLE next cycle, busy=0, done not pulsed, param_* keep last values.
//   abort and flag_write_over in same cycle: abort wins. abort and cfg_ena in IDLE: cfg_ena wins.
//  rst asserted mid-job: immediate return to reset state; no done.
// TESTING
//  cin=1,cout=1,bases 0x100/0x200/0x300 -> one param_ena (cycle 2), accum=0,last=1; write_over -> done.
//  cin=3,cout=2,xoff=0x40,yoff=0x24,zoff=0x80 -> 6 passes; x=0x100,0x140,0x180 repeat; y +0x24 each;
//   z=0x300 x3 then 0x380 x3; accum 0,1,1; last 0,0,1.
//  cfg_cout=0 -> cfg_err pulse, no param_ena, busy=0; cfg_ena while busy -> ignored, sequence unchanged.
//  xbase=2^AW-0x20, xoff=0x40, cin=2 -> second xaddr=0x20 (wrap).
//  abort during 2nd WAIT -> busy=0 next cycle, no done; later write_over ignored; new cfg_ena restarts at ci=co=0.
//  rst low mid-job -> all outputs 0 async; spurious write_over in IDLE -> no param_ena.

Source files
------------

// File: rtl/conv3d_sched_mc.sv
// conv3d_sched_mc: multi-channel pass scheduler for the conv3d datapath.
// Runs cin x cout conv2d passes, one per flag_write_over handshake.
module conv3d_sched_mc #(
  parameter int AW = 30,
  parameter int CW = 10,
  parameter int KS = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_ena,
  input  logic [AW-1:0] cfg_xbase,
  input  logic [AW-1:0] cfg_ybase,
  input  logic [AW-1:0] cfg_zbase,
  input  logic [AW-1:0] cfg_xoffset,
  input  logic [AW-1:0] cfg_yoffset,
  input  logic [AW-1:0] cfg_zoffset,
  input  logic [CW-1:0] cfg_cin,
  input  logic [CW-1:0] cfg_cout,
  input  logic [8:0]    cfg_width_in,
  input  logic [8:0]    cfg_height_out,
  input  logic [17:0]   cfg_length_in,
  input  logic [17:0]   cfg_length_out,
  input  logic          abort,
  input  logic          flag_write_over,
  output logic          param_ena,
  output logic [AW-1:0] param_xaddr,
  output logic [AW-1:0] param_yaddr,
  output logic [AW-1:0] param_zaddr,
  output logic [8:0]    param_width_in,
  output logic [8:0]    param_height_out,
  output logic [17:0]   param_length_in,
  output logic [17:0]   param_length_out,
  output logic          param_accum,
  output logic          param_last,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] NEXT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  if (KS < 1) begin : g_ks_chk
    $error("KS must be positive");
  end

  logic [2:0]    state;
  logic [CW-1:0] ci, co, cin_r, cout_r;
  logic [CW-1:0] cin_m1, cout_m1, nci, nco;
  logic [AW-1:0] xbase_r, xoff_r, yoff_r, zoff_r;
  logic [AW-1:0] x_r, y_r, z_r, nx, ny, nz;
  logic [8:0]    win_r, hout_r;
  logic [17:0]   lin_r, lout_r;
  logic          last_ci, last_co, cfg_ok;

  // Indices and addresses of the pass that follows the current one.
  always_comb begin
    cin_m1  = cin_r - ONE;
    cout_m1 = cout_r - ONE;
    last_ci = (ci == cin_m1);
    last_co = (co == cout_m1);
    cfg_ok  = (cfg_cin != '0) && (cfg_cout != '0);
    nci     = ci + ONE;
    nco     = co;
    nx      = x_r + xoff_r;
    nz      = z_r;
    ny      = y_r + yoff_r;
    if (last_ci) begin
      nci = '0;
      nco = co + ONE;
      nx  = xbase_r;
      nz  = z_r + zoff_r;
    end
  end

  // Pass sequencer. NEXT advances and issues in the same cycle so a new
  // pass goes out two cycles after write_over, like the first one does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      ci               <= '0;
      co               <= '0;
      cin_r            <= '0;
      cout_r           <= '0;
      xbase_r          <= '0;
      xoff_r           <= '0;
      yoff_r           <= '0;
      zoff_r           <= '0;
      x_r              <= '0;
      y_r              <= '0;
      z_r              <= '0;
      win_r            <= '0;
      hout_r           <= '0;
      lin_r            <= '0;
      lout_r           <= '0;
      param_ena        <= 1'b0;
      param_xaddr      <= '0;
      param_yaddr      <= '0;
      param_zaddr      <= '0;
      param_width_in   <= '0;
      param_height_out <= '0;
      param_length_in  <= '0;
      param_length_out <= '0;
      param_accum      <= 1'b0;
      param_last       <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      cfg_err          <= 1'b0;
    end else begin
      param_ena <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      if (state != IDLE && abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (cfg_ena && cfg_ok) begin
              cin_r   <= cfg_cin;
              cout_r  <= cfg_cout;
              xbase_r <= cfg_xbase;
              xoff_r  <= cfg_xoffset;
              yoff_r  <= cfg_yoffset;
              zoff_r  <= cfg_zoffset;
              x_r     <= cfg_xbase;
              y_r     <= cfg_ybase;
              z_r     <= cfg_zbase;
              win_r   <= cfg_width_in;
              hout_r  <= cfg_height_out;
              lin_r   <= cfg_length_in;
              lout_r  <= cfg_length_out;
              ci      <= '0;
              co      <= '0;
              busy    <= 1'b1;
              state   <= ISSUE;
            end else if (cfg_ena) begin
              cfg_err <= 1'b1;
            end
          end
          ISSUE: begin
            param_ena        <= 1'b1;
            param_xaddr      <= x_r;
            param_yaddr      <= y_r;
            param_zaddr      <= z_r;
            param_width_in   <= win_r;
            param_height_out <= hout_r;
            param_length_in  <= lin_r;
            param_length_out <= lout_r;
            param_accum      <= (ci != '0);
            param_last       <= last_ci;
            state            <= WAIT;
          end
          WAIT: begin
            if (flag_write_over) begin
              if (last_ci && last_co) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= DONE;
              end else begin
                state <= NEXT;
              end
            end
          end
          NEXT: begin
            ci               <= nci;
            co               <= nco;
            x_r              <= nx;
            y_r              <= ny;
            z_r              <= nz;
            param_ena        <= 1'b1;
            param_xaddr      <= nx;
            param_yaddr      <= ny;
            param_zaddr      <= nz;
            param_width_in   <= win_r;
            param_height_out <= hout_r;
            param_length_in  <= lin_r;
            param_length_out <= lout_r;
            param_accum      <= (nci != '0);
            param_last       <= (nci == cin_m1);
            state            <= WAIT;
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
